// File: rtl/csr_regfile_pkg.sv
// Shared CSR definitions: register indices, exception codes, field positions
// and writable-field masks for the LoongArch-style CSR file.
package csr_regfile_pkg;

    localparam logic [13:0] CSR_CRMD   = 14'h0000;
    localparam logic [13:0] CSR_PRMD   = 14'h0001;
    localparam logic [13:0] CSR_ECFG   = 14'h0004;
    localparam logic [13:0] CSR_ESTAT  = 14'h0005;
    localparam logic [13:0] CSR_ERA    = 14'h0006;
    localparam logic [13:0] CSR_BADV   = 14'h0007;
    localparam logic [13:0] CSR_EENTRY = 14'h000C;
    localparam logic [13:0] CSR_SAVE0  = 14'h0030;
    localparam logic [13:0] CSR_SAVE1  = 14'h0031;
    localparam logic [13:0] CSR_SAVE2  = 14'h0032;
    localparam logic [13:0] CSR_SAVE3  = 14'h0033;
    localparam logic [13:0] CSR_TID    = 14'h0040;
    localparam logic [13:0] CSR_TCFG   = 14'h0041;
    localparam logic [13:0] CSR_TVAL   = 14'h0042;
    localparam logic [13:0] CSR_TICLR  = 14'h0044;

    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    localparam int unsigned CRMD_PLV_LO   = 0;
    localparam int unsigned CRMD_PLV_HI   = 1;
    localparam int unsigned CRMD_IE       = 2;
    localparam int unsigned PRMD_PPLV_LO  = 0;
    localparam int unsigned PRMD_PPLV_HI  = 1;
    localparam int unsigned PRMD_PIE      = 2;
    localparam int unsigned TCFG_EN       = 0;
    localparam int unsigned TCFG_PERIODIC = 1;
    localparam int unsigned TICLR_CLR     = 0;

    localparam logic [31:0] CRMD_RESET   = 32'h0000_0008;
    localparam logic [31:0] CRMD_WMASK   = 32'h0000_01FF;
    localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007;
    localparam logic [31:0] ECFG_WMASK   = 32'h0000_1BFF;
    localparam logic [31:0] EENTRY_WMASK = 32'hFFFF_FFC0;
    localparam logic [1:0]  ESTAT_WMASK  = 2'b11;

    function automatic logic [31:0] wmerge(
        input logic [31:0] old_v,
        input logic [31:0] wmask,
        input logic [31:0] wvalue,
        input logic [31:0] fmask
    );
        return (old_v & ~(wmask & fmask)) | (wvalue & wmask & fmask);
    endfunction

    function automatic logic is_badv_ecode(input logic [5:0] ecode);
        return ecode inside {ECODE_ADE, ECODE_ALE, ECODE_TLBR, ECODE_PIL,
                             ECODE_PIS, ECODE_PIF, ECODE_PME, ECODE_PPI};
    endfunction

endpackage

// File: rtl/csr_regfile_timer.sv
// Constant timer: holds TVAL and the enable, and produces the expiry pulse
// that sets ESTAT.IS[11] in the parent.
module csr_timer
    import csr_regfile_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_tcfg_wr,
    input  logic [29:0] i_init_new,
    input  logic        i_en_new,
    input  logic [29:0] i_initval,
    input  logic        i_periodic,
    output logic [31:0] o_tval,
    output logic        o_expire
);
    logic [31:0] r_tval;
    logic        r_en;

    // A TCFG write restarts the count, so it masks an expiry in that cycle.
    assign o_expire = r_en & (r_tval == '0) & ~i_tcfg_wr;
    assign o_tval   = r_tval;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tval <= '0;
            r_en   <= 1'b0;
        end else if (i_tcfg_wr) begin
            r_tval <= {i_init_new, 2'b00};
            r_en   <= i_en_new;
        end else if (r_en) begin
            if (r_tval != '0) begin
                r_tval <= r_tval - 32'd1;
            end else if (i_periodic) begin
                r_tval <= {i_initval, 2'b00};
            end else begin
                r_tval <= '1;
                r_en   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/csr_regfile.sv
// CSR register file: masked software writes, exception/ERTN context save and
// restore, interrupt status sampling and the constant timer.
module csr_regfile #(
    parameter logic [31:0] TID_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr,
    input  logic        current_exc_fetch,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_entry,
    output logic        has_int
);
    import csr_regfile_pkg::*;

    logic [31:0] r_crmd;
    logic [31:0] r_prmd;
    logic [31:0] r_ecfg;
    logic [31:0] r_era;
    logic [31:0] r_badv;
    logic [31:0] r_eentry;
    logic [31:0] r_save [4];
    logic [31:0] r_tid;
    logic [31:0] r_tcfg;
    logic [1:0]  r_is_sw;
    logic [7:0]  r_is_hw;
    logic        r_is_ti;
    logic        r_is_ipi;
    logic [5:0]  r_ecode;
    logic [8:0]  r_esubcode;

    logic        w_wr;
    logic        w_tcfg_wr;
    logic        w_ticlr;
    logic [31:0] w_tcfg_new;
    logic [31:0] w_tval;
    logic        w_expire;
    logic [31:0] w_estat;
    logic        w_unused;

    // Software writes lose to exception and ERTN commits in the same cycle.
    assign w_wr       = csr_we & ~wb_ex & ~ertn_flush;
    assign w_tcfg_wr  = w_wr & (csr_num == CSR_TCFG);
    assign w_ticlr    = w_wr & (csr_num == CSR_TICLR)
                      & csr_wmask[TICLR_CLR] & csr_wvalue[TICLR_CLR];
    assign w_tcfg_new = wmerge(r_tcfg, csr_wmask, csr_wvalue, '1);
    assign w_unused   = csr_re ^ w_tcfg_new[TCFG_PERIODIC];

    assign w_estat = {1'b0, r_esubcode, r_ecode, 3'b000,
                      r_is_ipi, r_is_ti, 1'b0, r_is_hw, r_is_sw};

    assign has_int    = r_crmd[CRMD_IE] & |(w_estat[12:0] & r_ecfg[12:0]);
    assign ex_entry   = r_eentry;
    assign ertn_entry = r_era;

    csr_timer u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .i_tcfg_wr  (w_tcfg_wr),
        .i_init_new (w_tcfg_new[31:2]),
        .i_en_new   (w_tcfg_new[TCFG_EN]),
        .i_initval  (r_tcfg[31:2]),
        .i_periodic (r_tcfg[TCFG_PERIODIC]),
        .o_tval     (w_tval),
        .o_expire   (w_expire)
    );

    always_comb begin
        csr_rvalue = '0;
        case (csr_num)
            CSR_CRMD:   csr_rvalue = r_crmd;
            CSR_PRMD:   csr_rvalue = r_prmd;
            CSR_ECFG:   csr_rvalue = r_ecfg;
            CSR_ESTAT:  csr_rvalue = w_estat;
            CSR_ERA:    csr_rvalue = r_era;
            CSR_BADV:   csr_rvalue = r_badv;
            CSR_EENTRY: csr_rvalue = r_eentry;
            CSR_SAVE0:  csr_rvalue = r_save[0];
            CSR_SAVE1:  csr_rvalue = r_save[1];
            CSR_SAVE2:  csr_rvalue = r_save[2];
            CSR_SAVE3:  csr_rvalue = r_save[3];
            CSR_TID:    csr_rvalue = r_tid;
            CSR_TCFG:   csr_rvalue = r_tcfg;
            CSR_TVAL:   csr_rvalue = w_tval;
            default:    csr_rvalue = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_crmd     <= CRMD_RESET;
            r_prmd     <= '0;
            r_ecfg     <= '0;
            r_era      <= '0;
            r_badv     <= '0;
            r_eentry   <= '0;
            for (int unsigned i = 0; i < 4; i++) r_save[i] <= '0;
            r_tid      <= TID_RESET;
            r_tcfg     <= '0;
            r_is_sw    <= '0;
            r_is_hw    <= '0;
            r_is_ti    <= 1'b0;
            r_is_ipi   <= 1'b0;
            r_ecode    <= '0;
            r_esubcode <= '0;
        end else begin
            r_is_hw  <= hw_int_in;
            r_is_ipi <= ipi_int_in;
            if (w_expire)     r_is_ti <= 1'b1;
            else if (w_ticlr) r_is_ti <= 1'b0;

            if (wb_ex) begin
                r_prmd[PRMD_PPLV_HI:PRMD_PPLV_LO] <= r_crmd[CRMD_PLV_HI:CRMD_PLV_LO];
                r_prmd[PRMD_PIE]                  <= r_crmd[CRMD_IE];
                r_crmd[CRMD_PLV_HI:CRMD_PLV_LO]   <= '0;
                r_crmd[CRMD_IE]                   <= 1'b0;
                r_era      <= wb_pc;
                r_ecode    <= wb_ecode;
                r_esubcode <= wb_esubcode;
                if (is_badv_ecode(wb_ecode))
                    r_badv <= current_exc_fetch ? wb_pc : wb_vaddr;
            end else if (ertn_flush) begin
                r_crmd[CRMD_PLV_HI:CRMD_PLV_LO] <= r_prmd[PRMD_PPLV_HI:PRMD_PPLV_LO];
                r_crmd[CRMD_IE]                 <= r_prmd[PRMD_PIE];
            end else if (csr_we) begin
                case (csr_num)
                    CSR_CRMD:   r_crmd   <= wmerge(r_crmd, csr_wmask, csr_wvalue, CRMD_WMASK);
                    CSR_PRMD:   r_prmd   <= wmerge(r_prmd, csr_wmask, csr_wvalue, PRMD_WMASK);
                    CSR_ECFG:   r_ecfg   <= wmerge(r_ecfg, csr_wmask, csr_wvalue, ECFG_WMASK);
                    CSR_ESTAT:  r_is_sw  <= (r_is_sw & ~(csr_wmask[1:0] & ESTAT_WMASK))
                                          | (csr_wvalue[1:0] & csr_wmask[1:0] & ESTAT_WMASK);
                    CSR_ERA:    r_era    <= wmerge(r_era, csr_wmask, csr_wvalue, '1);
                    CSR_BADV:   r_badv   <= wmerge(r_badv, csr_wmask, csr_wvalue, '1);
                    CSR_EENTRY: r_eentry <= wmerge(r_eentry, csr_wmask, csr_wvalue, EENTRY_WMASK);
                    CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
                        r_save[csr_num[1:0]] <= wmerge(r_save[csr_num[1:0]], csr_wmask,
                                                       csr_wvalue, '1);
                    CSR_TID:    r_tid    <= wmerge(r_tid, csr_wmask, csr_wvalue, '1);
                    CSR_TCFG:   r_tcfg   <= w_tcfg_new;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/csr_regfile.md
CSR_REGFILE -- requirements
Module: csr_regfile

Interface
REQ-001 SHALL have parameter TID_RESET, default 32'h0, the reset value of TID.
REQ-002 SHALL have port clk, input, 1, the clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1, the reset: synchronous, active-low.
REQ-004 SHALL have port csr_re, input, 1, the read qualifier from WB; it does not gate csr_rvalue.
REQ-005 SHALL have port csr_num, input, 14, the CSR index for read and write.
REQ-006 SHALL have port csr_rvalue, output, 32, the combinational read data of csr_num.
REQ-007 SHALL have ports csr_we (input, 1), csr_wmask (input, 32) and csr_wvalue (input, 32), which form the masked write request.
REQ-008 SHALL have ports wb_ex (input, 1), wb_ecode (input, 6) and wb_esubcode (input, 9), which report an exception commit.
REQ-009 SHALL have ports wb_pc (input, 32), wb_vaddr (input, 32) and current_exc_fetch (input, 1), which supply the exception PC, the faulting address and the fetch-side flag.
REQ-010 SHALL have port ertn_flush, input, 1, the ERTN commit.
REQ-011 SHALL have ports hw_int_in (input, 8) and ipi_int_in (input, 1), which are the external interrupt levels.
REQ-012 SHALL have ports ex_entry (output, 32), ertn_entry (output, 32) and has_int (output, 1).

Function
REQ-013 SHALL implement CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC, SAVE0-3 0x30-0x33, TID 0x40, TCFG 0x41, TVAL 0x42 and TICLR 0x44.
REQ-014 SHALL return 0 on csr_rvalue for any unmapped csr_num.
REQ-015 SHALL give csr_rvalue the pre-update (current-cycle) value, so that csrxchg returns the old contents.
REQ-016 SHALL, when csr_we=1, set each writable field to (old & ~wmask) | (wvalue & wmask); all other bits keep their value.
REQ-017 SHALL limit writable fields to: CRMD[8:0]; PRMD[2:0]; ECFG[9:0] and ECFG[12:11]; ESTAT[1:0]; ERA, BADV, SAVE0-3, TID and TCFG in full; EENTRY[31:6]. All other bits read 0, and TVAL and TICLR read 0 except TVAL's count.
REQ-018 SHALL apply same-cycle priority wb_ex > ertn_flush > csr_we; a lower-priority event that loses is dropped entirely.
REQ-019 SHALL, on wb_ex: load PRMD.PPLV with CRMD.PLV and PRMD.PIE with CRMD.IE; clear CRMD.PLV and CRMD.IE; load ERA with wb_pc; load ESTAT.Ecode[21:16] with wb_ecode; load ESTAT.EsubCode[30:22] with wb_esubcode.
REQ-020 SHALL, on wb_ex with wb_ecode in {ADE 0x08, ALE 0x09, TLBR 0x3F, PIL 0x01, PIS 0x02, PIF 0x03, PME 0x04, PPI 0x07}, load BADV with wb_pc if current_exc_fetch=1, else with wb_vaddr.
REQ-021 SHALL, on ertn_flush, load CRMD.PLV with PRMD.PPLV and CRMD.IE with PRMD.PIE.
REQ-022 SHALL load ESTAT.IS[9:2] from hw_int_in and ESTAT.IS[12] from ipi_int_in every cycle (one-cycle latency).
REQ-023 SHALL, on a TCFG write, load TVAL with {new InitVal[31:2], 2'b00} and set internal timer_en to new TCFG.En.
REQ-024 SHALL decrement TVAL by 1 per cycle while timer_en=1 and TVAL != 0.
REQ-025 SHALL, when timer_en=1 and TVAL=0: set ESTAT.IS[11]; if TCFG.Periodic=1, reload {InitVal,2'b00}; otherwise set TVAL to 32'hFFFFFFFF and clear timer_en.
REQ-026 SHALL clear ESTAT.IS[11] on a TICLR write with wmask[0]&wvalue[0]=1; if timer expiry occurs in the same cycle, the set wins.
REQ-027 SHALL drive has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]), combinationally.
REQ-028 SHALL drive ex_entry = EENTRY and ertn_entry = ERA, combinationally from the registers.

Reset
REQ-029 SHALL, when resetn=0 at a clock edge, set CRMD to 32'h8 (DA=1, PLV=0, IE=0), TID to TID_RESET, timer_en to 0, and all other CSR state to 0.
REQ-030 SHALL give reset priority over every same-cycle event; outputs follow the reset values on the next cycle (has_int=0, ex_entry=0).

Structure
REQ-031 SHALL take CSR indices, ECODE/ESUBCODE constants and field bit positions from the shared header; none are redefined locally.
REQ-032 SHALL place TVAL, timer_en and the expiry pulse in one sub-module, csr_timer; the expiry pulse feeds ESTAT.IS[11].

Verification
REQ-033 SHALL cover: CRMD=0x7, ECFG.LIE=0x800, TCFG write 0x00000013 (InitVal=4, periodic, En) -> TVAL 16,15..0, IS[11] set on the 17th cycle, has_int=1, TVAL reload to 16.
REQ-034 SHALL cover: CRMD PLV=3, IE=1; wb_ex with ecode=0x09, wb_pc=0x1C000100, wb_vaddr=0x1003, current_exc_fetch=0 -> next cycle PRMD=0x7, CRMD[2:0]=0, ERA=0x1C000100, BADV=0x1003, ESTAT[21:16]=0x09.
REQ-035 SHALL cover: ertn_flush after REQ-034 -> CRMD PLV=3, IE=1; ertn_entry=0x1C000100.
REQ-036 SHALL cover: SAVE0=0xFFFFFFFF, csr_we with wmask=0x0000FFFF and wvalue=0x12345678 -> SAVE0=0xFFFF5678, and csr_rvalue shows 0xFFFFFFFF during the write cycle.
REQ-037 SHALL cover: wb_ex and csr_we to ERA in the same cycle -> ERA=wb_pc; a TICLR clear coinciding with timer expiry -> IS[11] remains 1.
REQ-038 SHALL cover: one-shot TCFG 0x9 -> TVAL reaches 0, then 0xFFFFFFFF, and holds.
